foo_wr_arb: RTL and testbench
=============================

Name: foo_wr_arb

Overview:
- Round-robin arbiter that shares one FOO_W-bit field of a foo_intf-style interface among NREQ requesters.
- Each requester offers a DATA_W-bit word. The winner's word is width-cast (truncated or zero-extended) to FOO_W and registered onto foo.
- foo is held valid for HOLD cycles per grant. Sits between producer modules and the interface instance they share.

Parameters:
- NREQ, 4, number of requesters; legal 2..16.
- DATA_W, 32, width of each requester's data word.
- FOO_W, 8, width of the shared interface field.
- HOLD, 2, cycles foo_vld stays high per grant; legal >= 1.
- OW, $clog2(NREQ), owner index width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held until the matching gnt bit is seen.
- req_data  in  NREQ*DATA_W  requester i's word is req_data[i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot, single-cycle acknowledge, registered.
- foo  out  FOO_W  shared field value, registered.
- foo_vld  out  1  foo is owned and valid.
- owner  out  OW  index of the current or last grantee.
- busy  out  1  high while in HOLD state.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, gnt=0, foo=0, foo_vld=0, owner=0, busy=0, rr pointer ptr=0, hold counter cnt=0.
- Reset is honoured in any state, including mid-HOLD. The in-flight grant is abandoned, no further gnt pulse is issued for it, and the requester must re-request.
- Effective request: ereq = req & ~gnt. A requester whose gnt bit is high this cycle is never considered, which prevents double-grant when req drops late.
- Winner selection (combinational): first set bit of ereq searching ptr, ptr+1, ..., wrapping modulo NREQ.
- Width cast: cast(i) = low FOO_W bits of requester i's word when FOO_W <= DATA_W; otherwise zero-extended to FOO_W.
- Arbitration point (AP): any cycle in IDLE, or the final HOLD cycle (cnt==0).
- At an AP with any ereq bit set, winner w, the following all take effect at the clock edge:
  - gnt <= onehot(w)
  - foo <= cast(w)
  - owner <= w
  - foo_vld <= 1
  - cnt <= HOLD-1
  - ptr <= (w+1) mod NREQ
  - state <= HOLD, busy <= 1
- At an AP with ereq==0:
  - state <= IDLE, foo_vld <= 0, busy <= 0, gnt <= 0.
  - foo and owner retain their last values.
- HOLD with cnt != 0: cnt <= cnt-1, gnt <= 0.
  - foo is stable; req and req_data changes are ignored.
- Latency: req seen in cycle N gives gnt, foo and foo_vld all valid in cycle N+1.
- Per grant, foo_vld is high for exactly HOLD cycles. Back-to-back grants have no bubble, so foo_vld stays continuously high under constant demand.
- Fairness: each requester with continuously asserted req is granted within NREQ grants.
- At most one gnt bit is set in any cycle. gnt is never set while rst was high at the previous edge.
- req_data is sampled only at the AP edge; the requester need not hold data after gnt.

Test Plan:
- Reset: drive garbage on req and req_data with rst=1 for 3 cycles, then release with req=0. Expect all outputs 0 and busy=0 for every cycle thereafter.
- Single request, cast: HOLD=2, req=4'b0001, req_data[0]=32'd5, req dropped on gnt. Expect:
  - Cycle+1: gnt=4'b0001, foo=8'd5, foo_vld=1, owner=0.
  - Cycle+2: foo_vld=1, gnt=0.
  - Cycle+3: foo_vld=0, foo stays 5.
- Truncation: req_data[2]=32'h1234_56A5 on requester 2. Expect foo=8'hA5, owner=2.
- Full contention: req=4'b1111 held continuously, data i = i+1, HOLD=2. Expect:
  - Grants in order 0,1,2,3,0 every 2 cycles.
  - foo sequence 1,2,3,4,1; foo_vld never drops.
- Round-robin pointer: after a grant to 2, present req=4'b0101. Expect requester 0 granted next (search starts at 3), then 2.
- HOLD=1 with requester 1 holding req one cycle after its gnt, others idle. Expect exactly one gnt pulse to 1; foo_vld high for 1 cycle only.
- Reset mid-HOLD: rst=1 in the cycle after a grant to 3. Expect:
  - Next cycle: foo=0, foo_vld=0, busy=0.
  - With req=4'b1111 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/foo_wr_arb.sv
// foo_wr_arb: round-robin arbiter granting one requester at a time to drive the shared foo field for HOLD cycles
module foo_wr_arb #(
    parameter int NREQ = 4,
    parameter int DATA_W = 32,
    parameter int FOO_W = 8,
    parameter int HOLD = 2,
    localparam int OW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [FOO_W-1:0]       foo,
    output logic                   foo_vld,
    output logic [OW-1:0]          owner,
    output logic                   busy
);
    localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
    state_t state, state_n;
    logic [OW-1:0] ptr, ptr_n, win, owner_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NREQ-1:0] ereq, gnt_n;
    logic [DATA_W-1:0] word;
    logic [DATA_W+FOO_W-1:0] ext;
    logic [FOO_W-1:0] foo_n;
    logic ap, vld_n, busy_n;
    always_comb begin
        ereq = req & ~gnt;
        win = '0;
        // descending scan so the candidate closest to ptr is the last one written
        for (int k = NREQ - 1; k >= 0; k--)
            if (ereq[(int'(ptr) + k) % NREQ]) win = OW'((int'(ptr) + k) % NREQ);
        word = req_data[win*DATA_W +: DATA_W];
        ext = {{FOO_W{1'b0}}, word};
        ap = state == ST_IDLE || cnt == '0;
        state_n = state;
        gnt_n = '0;
        foo_n = foo;
        vld_n = foo_vld;
        owner_n = owner;
        busy_n = busy;
        ptr_n = ptr;
        cnt_n = cnt;
        if (ap && |ereq) begin
            state_n = ST_HOLD;
            gnt_n = NREQ'(1) << win;
            foo_n = ext[FOO_W-1:0];
            vld_n = 1'b1;
            owner_n = win;
            busy_n = 1'b1;
            ptr_n = win == OW'(NREQ - 1) ? '0 : win + 1'b1;
            cnt_n = CW'(HOLD - 1);
        end else if (ap) begin
            state_n = ST_IDLE;
            vld_n = 1'b0;
            busy_n = 1'b0;
        end else begin
            cnt_n = cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt <= '0;
            foo <= '0;
            foo_vld <= 1'b0;
            owner <= '0;
            busy <= 1'b0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            foo <= foo_n;
            foo_vld <= vld_n;
            owner <= owner_n;
            busy <= busy_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_foo_wr_arb.sv
// tb_foo_wr_arb: directed table-driven check of foo_wr_arb with HOLD=2, plus a HOLD=1 sequence
module tb_foo_wr_arb;
    logic clk = 0;
    logic rst = 1;
    logic [3:0] req = '0;
    logic [127:0] req_data = '0;
    logic [3:0] gnt, gnt1;
    logic [7:0] foo, foo1;
    logic foo_vld, vld1, busy, busy1;
    logic [1:0] owner, owner1;
    int n_chk = 0;
    int n_fail = 0;
    int pulses;
    always #5 clk = ~clk;
    foo_wr_arb #(.NREQ(4), .DATA_W(32), .FOO_W(8), .HOLD(2)) u0 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .foo(foo), .foo_vld(foo_vld), .owner(owner), .busy(busy)
    );
    foo_wr_arb #(.NREQ(4), .DATA_W(32), .FOO_W(8), .HOLD(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt1), .foo(foo1), .foo_vld(vld1), .owner(owner1), .busy(busy1)
    );
    typedef struct {
        logic rst;
        logic [3:0] req;
        logic [127:0] data;
        logic [3:0] gnt;
        logic [7:0] foo;
        logic vld;
        logic [1:0] owner;
        logic busy;
    } vec_t;
    vec_t tbl[$];
    localparam logic [127:0] DG = 128'hDEADBEEF_CAFEF00D_5A5A5A5A_A5A5A5A5;
    localparam logic [127:0] DI = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] D5 = {32'd0, 32'd0, 32'd0, 32'd5};
    localparam logic [127:0] DT = {32'd0, 32'h1234_56A5, 32'd0, 32'd0};
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask
    task automatic add(input logic r, input logic [3:0] rq, input logic [127:0] d, input logic [3:0] g,
                       input logic [7:0] f, input logic v, input logic [1:0] o, input logic b);
        tbl.push_back('{r, rq, d, g, f, v, o, b});
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        // reset with garbage on the inputs
        add(1, 4'b1111, DG, 4'b0000, 8'h00, 0, 0, 0);
        add(1, 4'b1010, DG, 4'b0000, 8'h00, 0, 0, 0);
        add(1, 4'b0111, DG, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b0000, DG, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b0000, DG, 4'b0000, 8'h00, 0, 0, 0);
        // single request, dropped on gnt
        add(0, 4'b0001, D5, 4'b0001, 8'd5, 1, 0, 1);
        add(0, 4'b0000, D5, 4'b0000, 8'd5, 1, 0, 1);
        add(0, 4'b0000, D5, 4'b0000, 8'd5, 0, 0, 0);
        // truncation on requester 2
        add(0, 4'b0100, DT, 4'b0100, 8'hA5, 1, 2, 1);
        add(0, 4'b0000, DT, 4'b0000, 8'hA5, 1, 2, 1);
        add(0, 4'b0000, DT, 4'b0000, 8'hA5, 0, 2, 0);
        // pointer at 3: 0 wins before 2
        add(0, 4'b0101, DI, 4'b0001, 8'd1, 1, 0, 1);
        add(0, 4'b0100, DI, 4'b0000, 8'd1, 1, 0, 1);
        add(0, 4'b0100, DI, 4'b0100, 8'd3, 1, 2, 1);
        add(0, 4'b0000, DI, 4'b0000, 8'd3, 1, 2, 1);
        add(0, 4'b0000, DI, 4'b0000, 8'd3, 0, 2, 0);
        // full contention from a fresh pointer
        add(1, 4'b0000, DI, 4'b0000, 8'd0, 0, 0, 0);
        add(0, 4'b1111, DI, 4'b0001, 8'd1, 1, 0, 1);
        add(0, 4'b1111, DI, 4'b0000, 8'd1, 1, 0, 1);
        add(0, 4'b1111, DI, 4'b0010, 8'd2, 1, 1, 1);
        add(0, 4'b1111, DI, 4'b0000, 8'd2, 1, 1, 1);
        add(0, 4'b1111, DI, 4'b0100, 8'd3, 1, 2, 1);
        add(0, 4'b1111, DI, 4'b0000, 8'd3, 1, 2, 1);
        add(0, 4'b1111, DI, 4'b1000, 8'd4, 1, 3, 1);
        add(0, 4'b1111, DI, 4'b0000, 8'd4, 1, 3, 1);
        add(0, 4'b1111, DI, 4'b0001, 8'd1, 1, 0, 1);
        add(0, 4'b1111, DI, 4'b0000, 8'd1, 1, 0, 1);
        // grant to 3 then reset mid-HOLD; pointer restarts at 0
        add(0, 4'b1000, DI, 4'b1000, 8'd4, 1, 3, 1);
        add(1, 4'b1111, DI, 4'b0000, 8'd0, 0, 0, 0);
        add(0, 4'b1111, DI, 4'b0001, 8'd1, 1, 0, 1);
        add(0, 4'b0000, DI, 4'b0000, 8'd1, 1, 0, 1);
        add(0, 4'b0000, DI, 4'b0000, 8'd1, 0, 0, 0);
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            req_data = tbl[i].data;
            tick();
            check("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
            check("foo", i, 32'(foo), 32'(tbl[i].foo));
            check("foo_vld", i, 32'(foo_vld), 32'(tbl[i].vld));
            check("owner", i, 32'(owner), 32'(tbl[i].owner));
            check("busy", i, 32'(busy), 32'(tbl[i].busy));
            check("gnt_onehot", i, 32'($onehot0(gnt)), 32'd1);
        end
        // HOLD=1: requester 1 keeps req one cycle past its gnt
        rst = 1;
        req = '0;
        req_data = DI;
        tick();
        check("h1_rst_gnt", 100, 32'(gnt1), 32'd0);
        check("h1_rst_vld", 100, 32'(vld1), 32'd0);
        rst = 0;
        req = 4'b0010;
        pulses = 0;
        tick();
        pulses += $countones(gnt1);
        check("h1_gnt", 101, 32'(gnt1), 32'b0010);
        check("h1_foo", 101, 32'(foo1), 32'd2);
        check("h1_vld", 101, 32'(vld1), 32'd1);
        check("h1_owner", 101, 32'(owner1), 32'd1);
        check("h1_busy", 101, 32'(busy1), 32'd1);
        tick();
        pulses += $countones(gnt1);
        check("h1_gnt_late", 102, 32'(gnt1), 32'd0);
        check("h1_vld_drop", 102, 32'(vld1), 32'd0);
        check("h1_busy_drop", 102, 32'(busy1), 32'd0);
        check("h1_foo_keep", 102, 32'(foo1), 32'd2);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            pulses += $countones(gnt1);
            check("h1_vld_idle", 103 + c, 32'(vld1), 32'd0);
        end
        check("h1_pulses", 106, 32'(pulses), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
